// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges NCH SRAM-like master ports onto one memory port and
// routes each in-order data_ok back to the channel that issued it.
module sram_like_arbiter #(
    parameter  int NCH    = 2,
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    parameter  int RR     = 1,
    localparam int SW     = DATA_W / 8,
    localparam int OW     = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NCH-1:0]        ch_req,
    input  logic [NCH-1:0]        ch_wr,
    input  logic [2*NCH-1:0]      ch_size,
    input  logic [SW*NCH-1:0]     ch_wstrb,
    input  logic [ADDR_W*NCH-1:0] ch_addr,
    input  logic [DATA_W*NCH-1:0] ch_wdata,
    output logic [NCH-1:0]        ch_addr_ok,
    output logic [NCH-1:0]        ch_data_ok,
    output logic [DATA_W-1:0]     ch_rdata,
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [1:0]            mem_size,
    output logic [SW-1:0]         mem_wstrb,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_addr_ok,
    input  logic                  mem_data_ok,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [OW-1:0]         outstanding,
    output logic                  proto_err
);
    localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam logic [IW:0]   NCH_W = (IW+1)'(NCH);
    localparam logic [OW-1:0] FULL  = OW'(DEPTH);

    logic          lock_v_q, lock_v_d;
    logic [IW-1:0] lock_ch_q, lock_ch_d, rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [OW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [IW-1:0] fifo_q [DEPTH];
    logic [IW-1:0] fifo_d [DEPTH];
    logic [IW-1:0] grant, arb, idx;
    logic [IW:0]   sum;
    logic          hs, pop;

    // Scan downwards so the requester closest to the search start wins last.
    always_comb begin
        arb = '0;
        sum = '0;
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            sum = (RR != 0 ? {1'b0, rr_ptr_q} : '0) + (IW+1)'(i);
            idx = IW'(sum >= NCH_W ? sum - NCH_W : sum);
            if (ch_req[idx]) arb = idx;
        end
        grant = lock_v_q && ch_req[lock_ch_q] ? lock_ch_q : arb;
    end

    assign mem_req     = |ch_req && cnt_q != FULL;
    assign hs          = mem_req && mem_addr_ok;
    assign pop         = mem_data_ok && cnt_q != '0;
    assign mem_wr      = ch_wr[grant];
    assign mem_size    = ch_size[grant*2 +: 2];
    assign mem_wstrb   = ch_wstrb[grant*SW +: SW];
    assign mem_addr    = ch_addr[grant*ADDR_W +: ADDR_W];
    assign mem_wdata   = ch_wdata[grant*DATA_W +: DATA_W];
    assign ch_addr_ok  = hs && resetn ? NCH'(1) << grant : '0;
    assign ch_data_ok  = pop && resetn ? NCH'(1) << fifo_q[rp_q] : '0;
    assign ch_rdata    = mem_rdata;
    assign outstanding = cnt_q;
    assign proto_err   = err_q;

    always_comb begin
        fifo_d = fifo_q;
        if (hs) fifo_d[wp_q] = grant;
        wp_d      = wp_q + PW'(hs);
        rp_d      = rp_q + PW'(pop);
        cnt_d     = cnt_q + OW'(hs) - OW'(pop);
        err_d     = err_q | (mem_data_ok && cnt_q == '0);
        rr_ptr_d  = hs ? (({1'b0, grant} + 1'b1 == NCH_W) ? '0 : grant + 1'b1) : rr_ptr_q;
        lock_v_d  = hs ? 1'b0 : mem_req ? 1'b1 : lock_v_q && ch_req[lock_ch_q];
        lock_ch_d = !hs && mem_req ? grant : lock_ch_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_v_q  <= 1'b0;
            lock_ch_q <= '0;
            rr_ptr_q  <= '0;
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            fifo_q    <= '{default: '0};
        end else begin
            lock_v_q  <= lock_v_d;
            lock_ch_q <= lock_ch_d;
            rr_ptr_q  <= rr_ptr_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            fifo_q    <= fifo_d;
        end
    end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: vector table, directed corner sequences and a random run
// against a queue-based reference model; a fixed-priority twin checks RR=0.
module tb_sram_like_arbiter;
    localparam int NCH = 3, AW = 32, DW = 32, DEPTH = 4, SW = 4, OW = 3;

    logic clk = 1'b0, resetn = 1'b0;
    logic [NCH-1:0] ch_req = '0, ch_wr = '0;
    logic [2*NCH-1:0] ch_size = '0;
    logic [SW*NCH-1:0] ch_wstrb = '0;
    logic [AW*NCH-1:0] ch_addr = '0;
    logic [DW*NCH-1:0] ch_wdata = '0;
    logic mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic [NCH-1:0] ch_addr_ok, ch_data_ok, fx_addr_ok, fx_data_ok;
    logic [DW-1:0] ch_rdata, fx_rdata, mem_wdata, fx_wdata;
    logic mem_req, mem_wr, fx_req, fx_wr, proto_err, fx_err, fx_dok;
    logic [1:0] mem_size, fx_size;
    logic [SW-1:0] mem_wstrb, fx_wstrb;
    logic [AW-1:0] mem_addr, fx_addr;
    logic [OW-1:0] outstanding, fx_out;

    assign fx_dok = fx_out != '0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RR(1)) dut (
        .clk(clk), .resetn(resetn), .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size),
        .ch_wstrb(ch_wstrb), .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_addr_ok(ch_addr_ok),
        .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata), .mem_req(mem_req), .mem_wr(mem_wr),
        .mem_size(mem_size), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .outstanding(outstanding), .proto_err(proto_err));

    sram_like_arbiter #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RR(0)) fx (
        .clk(clk), .resetn(resetn), .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size),
        .ch_wstrb(ch_wstrb), .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_addr_ok(fx_addr_ok),
        .ch_data_ok(fx_data_ok), .ch_rdata(fx_rdata), .mem_req(fx_req), .mem_wr(fx_wr),
        .mem_size(fx_size), .mem_wstrb(fx_wstrb), .mem_addr(fx_addr), .mem_wdata(fx_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(fx_dok), .mem_rdata(mem_rdata),
        .outstanding(fx_out), .proto_err(fx_err));

    int checks = 0, errors = 0;

    typedef struct {
        logic [2:0]  req;
        logic        aok, dok;
        logic [31:0] rd;
        logic        mreq;
        logic [2:0]  xaok, xdok;
        int          xout;
        logic        xerr;
    } vec_t;

    vec_t tv[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [NCH-1:0] r, input logic a, input logic d, input logic [31:0] rd);
        ch_req = r;
        mem_addr_ok = a;
        mem_data_ok = d;
        mem_rdata = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive('0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        int q[$];
        int rr, lock_ch, g, sz;
        bit lock_v, err, mreq, hs, pop;
        logic [2:0] r;
        logic [2:0] xa;
        logic [31:0] xaddr;

        tv[0]  = '{3'b010, 1, 0, 32'h0,        1, 3'b010, 3'b000, 0, 0};
        tv[1]  = '{3'b000, 0, 0, 32'h0,        0, 3'b000, 3'b000, 1, 0};
        tv[2]  = '{3'b000, 0, 1, 32'hDEADBEEF, 0, 3'b000, 3'b010, 1, 0};
        tv[3]  = '{3'b000, 0, 0, 32'h0,        0, 3'b000, 3'b000, 0, 0};
        tv[4]  = '{3'b001, 1, 0, 32'h0,        1, 3'b001, 3'b000, 0, 0};
        tv[5]  = '{3'b010, 1, 0, 32'h0,        1, 3'b010, 3'b000, 1, 0};
        tv[6]  = '{3'b001, 1, 0, 32'h0,        1, 3'b001, 3'b000, 2, 0};
        tv[7]  = '{3'b000, 0, 1, 32'h11,       0, 3'b000, 3'b001, 3, 0};
        tv[8]  = '{3'b000, 0, 1, 32'h22,       0, 3'b000, 3'b010, 2, 0};
        tv[9]  = '{3'b000, 0, 1, 32'h33,       0, 3'b000, 3'b001, 1, 0};
        tv[10] = '{3'b000, 0, 1, 32'h44,       0, 3'b000, 3'b000, 0, 0};
        tv[11] = '{3'b000, 0, 0, 32'h0,        0, 3'b000, 3'b000, 0, 1};
        tv[12] = '{3'b100, 1, 0, 32'h0,        1, 3'b100, 3'b000, 0, 1};
        tv[13] = '{3'b010, 1, 1, 32'h55,       1, 3'b010, 3'b100, 1, 1};
        tv[14] = '{3'b000, 0, 1, 32'h66,       0, 3'b000, 3'b010, 1, 1};
        tv[15] = '{3'b000, 0, 0, 32'h0,        0, 3'b000, 3'b000, 0, 1};

        ch_addr  = {32'h200, 32'h100, 32'h000};
        ch_wdata = {32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};

        resetn = 1'b0;
        drive(3'b010, 1, 1, 32'h0);
        #3;
        chk("rst_mem_req", mem_req, 1);
        chk("rst_addr_ok", ch_addr_ok, 0);
        chk("rst_data_ok", ch_data_ok, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_proto_err", proto_err, 0);
        do_reset();

        foreach (tv[i]) begin
            drive(tv[i].req, tv[i].aok, tv[i].dok, tv[i].rd);
            @(negedge clk);
            chk($sformatf("tv%0d_mem_req", i), mem_req, tv[i].mreq);
            chk($sformatf("tv%0d_addr_ok", i), ch_addr_ok, tv[i].xaok);
            chk($sformatf("tv%0d_data_ok", i), ch_data_ok, tv[i].xdok);
            chk($sformatf("tv%0d_outstanding", i), outstanding, tv[i].xout);
            chk($sformatf("tv%0d_proto_err", i), proto_err, tv[i].xerr);
            chk($sformatf("tv%0d_rdata", i), ch_rdata, tv[i].rd);
            xa = tv[i].xaok;
            if (xa != 0) chk($sformatf("tv%0d_mem_addr", i), mem_addr, xa[0] ? 32'h0 : xa[1] ? 32'h100 : 32'h200);
            tick();
        end

        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(c == 0 ? 3'b010 : c == 4 ? 3'b001 : 3'b011, c >= 3, 0, 0);
            @(negedge clk);
            chk($sformatf("lock%0d_mem_req", c), mem_req, 1);
            chk($sformatf("lock%0d_mem_addr", c), mem_addr, c == 4 ? 32'h0 : 32'h100);
            chk($sformatf("lock%0d_addr_ok", c), ch_addr_ok, c < 3 ? 3'b000 : c == 3 ? 3'b010 : 3'b001);
            tick();
        end

        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(3'b111, 1, i > 0, 32'h0);
            @(negedge clk);
            chk($sformatf("rr%0d_addr_ok", i), ch_addr_ok, 3'b001 << (i % 3));
            if (i > 0) chk($sformatf("rr%0d_data_ok", i), ch_data_ok, 3'b001 << ((i - 1) % 3));
            chk($sformatf("fixed%0d_addr_ok", i), fx_addr_ok, 3'b001);
            chk($sformatf("fixed%0d_mem_addr", i), fx_addr, 32'h0);
            tick();
        end

        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(3'b001, 1, i == 5, 32'h0);
            @(negedge clk);
            chk($sformatf("full%0d_mem_req", i), mem_req, i < 4 || i == 6);
            chk($sformatf("full%0d_outstanding", i), outstanding, i < 4 ? i : i == 6 ? 3 : 4);
            chk($sformatf("full%0d_data_ok", i), ch_data_ok, i == 5 ? 3'b001 : 3'b000);
            tick();
        end

        do_reset();
        drive('0, 0, 1, 32'h0);
        @(negedge clk);
        chk("spur_data_ok", ch_data_ok, 0);
        chk("spur_err_before", proto_err, 0);
        tick();
        drive(3'b001, 1, 0, 32'h0);
        #1;
        chk("spur_err_sticky", proto_err, 1);
        tick();
        drive('0, 0, 0, 32'h0);
        chk("spur_outstanding", outstanding, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_err_clear", proto_err, 0);
        chk("async_out_clear", outstanding, 0);
        tick();
        resetn = 1'b1;
        drive('0, 0, 1, 32'h0);
        @(negedge clk);
        chk("late_data_ok", ch_data_ok, 0);
        tick();
        drive('0, 0, 0, 32'h0);
        chk("late_err", proto_err, 1);

        do_reset();
        rr = 0; lock_v = 0; lock_ch = 0; err = 0;
        for (int n = 0; n < 400; n++) begin
            r = 3'($urandom_range(0, 7));
            if (lock_v) r[lock_ch] = 1'b1;
            ch_addr  = {$urandom, $urandom, $urandom};
            ch_wdata = {$urandom, $urandom, $urandom};
            ch_wr    = 3'($urandom);
            drive(r, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, $urandom);
            g = 0;
            if (lock_v) g = lock_ch;
            else for (int k = NCH - 1; k >= 0; k--) if (r[(rr + k) % NCH]) g = (rr + k) % NCH;
            sz = q.size();
            mreq = r != 0 && sz != DEPTH;
            hs = mreq && mem_addr_ok;
            pop = mem_data_ok && sz > 0;
            @(negedge clk);
            chk($sformatf("rnd%0d_mem_req", n), mem_req, mreq);
            chk($sformatf("rnd%0d_addr_ok", n), ch_addr_ok, hs ? 3'b001 << g : 3'b000);
            chk($sformatf("rnd%0d_data_ok", n), ch_data_ok, pop ? 3'b001 << q[0] : 3'b000);
            chk($sformatf("rnd%0d_outstanding", n), outstanding, sz);
            chk($sformatf("rnd%0d_proto_err", n), proto_err, err);
            if (mreq) begin
                xaddr = ch_addr[g*32 +: 32];
                chk($sformatf("rnd%0d_mem_addr", n), mem_addr, xaddr);
                chk($sformatf("rnd%0d_mem_wdata", n), mem_wdata, ch_wdata[g*32 +: 32]);
                chk($sformatf("rnd%0d_mem_wr", n), mem_wr, ch_wr[g]);
            end
            if (mem_data_ok && sz == 0) err = 1;
            if (pop) void'(q.pop_front());
            if (hs) begin
                q.push_back(g);
                rr = (g + 1) % NCH;
                lock_v = 0;
            end else if (mreq) begin
                lock_v = 1;
                lock_ch = g;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Parametrised N-channel arbiter that merges several SRAM-like master ports (req / addr_ok / data_ok handshake, as used by the core's instruction and data ports) onto one SRAM-like memory port. It tracks multiple outstanding transactions and routes each returning `data_ok` to the channel that issued the request. It sits between the CPU top and the memory bridge, replacing the fixed two-port wiring with a generalised, depth-configurable block.

## Interface
- `NCH`, 2: number of master channels (1..8); channel 0 is the lowest index.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width, a multiple of 8; `SW = DATA_W/8`.
- `DEPTH`, 4: maximum outstanding transactions (power of two, ≥2).
- `RR`, 1: 0 = fixed priority (lowest index wins); 1 = round-robin.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ch_req`  in  NCH  per-channel request.
- `ch_wr`  in  NCH  per-channel write flag.
- `ch_size`  in  2·NCH  per-channel size (0 = byte, 1 = half, 2 = word).
- `ch_wstrb`  in  SW·NCH  per-channel byte strobes.
- `ch_addr`  in  ADDR_W·NCH  per-channel address.
- `ch_wdata`  in  DATA_W·NCH  per-channel write data.
- `ch_addr_ok`  out  NCH  address accepted, one-hot or zero.
- `ch_data_ok`  out  NCH  response for the oldest outstanding request of that channel, one-hot or zero.
- `ch_rdata`  out  DATA_W  broadcast copy of `mem_rdata`.
- `mem_req`, `mem_wr`, `mem_size`, `mem_wstrb`, `mem_addr`, `mem_wdata`  out  1/1/2/SW/ADDR_W/DATA_W  muxed request of the granted channel.
- `mem_addr_ok`  in  1  memory accepted the current request.
- `mem_data_ok`  in  1  memory returns one response, in order.
- `mem_rdata`  in  DATA_W  read data.
- `outstanding`  out  clog2(DEPTH)+1  number of transactions in flight.
- `proto_err`  out  1  sticky flag: `mem_data_ok` arrived with nothing outstanding.

## Operation
**Grant (combinational).**
- The candidate set is `ch_req`.
- `RR=0`: the lowest-index requester wins.
- `RR=1`: the first requester at or after `rr_ptr`, searching with wrap-around, wins.

**Lock.**
- Lock state is `{lock_v, lock_ch}`.
- If `mem_req=1` and `mem_addr_ok=0` at a clock edge, set `lock_v=1` and `lock_ch=grant`.
- While locked, the grant is forced to `lock_ch`, whatever other requests are present. This keeps `mem_addr`, `mem_wdata` and the other request fields stable until the handshake, as the protocol requires.
- The handshake (`mem_req & mem_addr_ok`) clears the lock.
- A locked channel that drops `ch_req` is a master protocol violation. The arbiter clears the lock and arbitrates again in the next cycle.

**Issue.**
- `mem_req = (|ch_req) & (outstanding != DEPTH)`.
- All `mem_*` request fields are the granted channel's slice.
- `ch_addr_ok[grant] = mem_addr_ok & mem_req`.

**ID FIFO.**
- DEPTH entries, each holding a clog2(NCH)-bit channel index (minimum 1 bit).
- On a handshake, push the granted index.
- On `mem_data_ok` with `outstanding > 0`: assert `ch_data_ok[head] = 1` in the same cycle, then pop.
- The read and write pointers wrap modulo DEPTH.
- Push and pop in the same cycle leave `outstanding` unchanged.

**Round-robin pointer.** On each handshake, `rr_ptr ← (grant+1) mod NCH`. Channel NCH−1 wraps to 0.

**Error.** `mem_data_ok` with `outstanding == 0` sets `proto_err`. Nothing is popped and no `ch_data_ok` is asserted. Only reset clears `proto_err`.

## Timing
- The request path is zero latency: `ch_*` to `mem_*` and `mem_addr_ok` to `ch_addr_ok` are purely combinational.
- The response path is zero latency: `mem_data_ok` to `ch_data_ok` is combinational from the registered FIFO head.
- **Reset** (asynchronous, `resetn=0`):
  - `lock_v=0`, `rr_ptr=0`, pointers 0, `outstanding=0`, `proto_err=0`.
  - `ch_addr_ok` and `ch_data_ok` are 0.
  - `mem_req` follows `|ch_req` immediately.
- **Reset mid-operation:** in-flight transactions are discarded. A later `mem_data_ok` with nothing outstanding sets `proto_err`.
- **Full:** with `outstanding == DEPTH`, `mem_req=0` even if a pop occurs in the same cycle. Issue resumes the cycle after the pop.
- **Empty:** see Error.
- **Simultaneous handshake and data_ok:** both happen. The pop refers to the old head, and the pushed index never returns in the same cycle.

## Test plan
- **Single read:** `NCH=2`, ch1 requests address 0x100. The memory gives `addr_ok` in cycle 0 and `data_ok` in cycle 2 with data 0xDEADBEEF. Required: `ch_addr_ok=2'b10` in cycle 0, `ch_data_ok=2'b10` with `ch_rdata=0xDEADBEEF` in cycle 2, and `outstanding` reads 1 then 0.
- **Lock hold:** ch1 requests and `mem_addr_ok` is held 0 for 3 cycles; ch0 starts requesting in cycle 1. Required: `mem_addr` stays at ch1's address in all 4 cycles, and ch0 is granted only after ch1's handshake.
- **Round-robin:** `RR=1`, `NCH=3`, all channels request continuously and `addr_ok` is always 1. Required grant order is 0,1,2,0,1,2. With `RR=0` under the same stimulus, the grant is always 0.
- **Full stall:** `DEPTH=4`, ch0 issues 4 requests with no `data_ok`. Required: `mem_req=0` in cycle 4 with `outstanding=4`. After one `data_ok`, `mem_req` is 1 again in the next cycle.
- **Out-of-channel return order:** issue in the order ch0, ch1, ch0, then return 3 `data_ok`s. Required: `ch_data_ok` is 01, 10, 01 in that order.
- **Spurious response:** `data_ok` arrives with nothing outstanding. Required: `proto_err=1` and no `ch_data_ok`. Asserting `resetn=0` asynchronously mid-cycle clears `proto_err` and `outstanding` without waiting for a clock edge.
